// File: rtl/pwm_pkg.sv
// Shared types and defaults for the complementary PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W    = 8;
  localparam int unsigned PWM_PERIOD   = 250;
  localparam int unsigned PWM_DEAD_CYC = 16;
  localparam int unsigned PWM_DEAD_W   = 5;

  typedef enum logic [2:0] {
    OFF,
    LOW,
    DT_R,
    HIGH,
    DT_F
  } pwm_state_e;

  // Saturate a requested duty to the period length.
  function automatic logic [31:0] duty_clamp(input logic [31:0] duty, input logic [31:0] period);
    return (duty > period) ? period : duty;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time FSM: turns the raw PWM level into a non-overlapping hi/lo pair.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD_CYC = PWM_DEAD_CYC,
  parameter int unsigned DEAD_W   = PWM_DEAD_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam logic [DEAD_W-1:0] DT_LOAD = DEAD_W'(DEAD_CYC - 1);

  pwm_state_e        state_q;
  logic [DEAD_W-1:0] dt_q;
  logic              hi_q;
  logic              lo_q;

  // Outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      dt_q    <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else if (!en) begin
      state_q <= OFF;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          state_q <= DT_F;
          dt_q    <= DT_LOAD;
        end
        LOW: begin
          if (raw) begin
            state_q <= DT_R;
            dt_q    <= DT_LOAD;
            lo_q    <= 1'b0;
          end
        end
        DT_R: begin
          if (!raw) begin
            state_q <= LOW;
            lo_q    <= 1'b1;
          end else if (dt_q == '0) begin
            state_q <= HIGH;
            hi_q    <= 1'b1;
          end else begin
            dt_q <= dt_q - DEAD_W'(1);
          end
        end
        HIGH: begin
          if (!raw) begin
            state_q <= DT_F;
            dt_q    <= DT_LOAD;
            hi_q    <= 1'b0;
          end
        end
        DT_F: begin
          if (raw) begin
            state_q <= DT_R;
            dt_q    <= DT_LOAD;
          end else if (dt_q == '0) begin
            state_q <= LOW;
            lo_q    <= 1'b1;
          end else begin
            dt_q <= dt_q - DEAD_W'(1);
          end
        end
        default: begin
          state_q <= OFF;
          hi_q    <= 1'b0;
          lo_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM with dead time; steps on rising edges of the 125 kHz divider output.
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = PWM_CNT_W,
  parameter int unsigned PERIOD   = PWM_PERIOD,
  parameter int unsigned DEAD_CYC = PWM_DEAD_CYC,
  parameter int unsigned DEAD_W   = PWM_DEAD_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_in,
  input  logic           en,
  input  logic [CNT_W:0] duty_in,
  input  logic           duty_load,
  output logic           pwm_hi,
  output logic           pwm_lo,
  output logic           period_start,
  output logic           duty_pending
);

  localparam int unsigned DUTY_W = CNT_W + 1;

  logic              tick_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic [DUTY_W-1:0] pend_q, pend_d;
  logic              pending_q, pending_d;
  logic              raw_q;
  logic              ps_q;

  logic              step_c;
  logic              wrap_c;
  logic [DUTY_W-1:0] duty_clamped_c;

  assign step_c         = tick_in & ~tick_q;
  assign wrap_c         = en & step_c & (cnt_q == CNT_W'(PERIOD - 1));
  assign duty_clamped_c = DUTY_W'(duty_clamp(32'(duty_in), 32'(PERIOD)));

  always_comb begin
    cnt_d = cnt_q;
    if (!en)         cnt_d = '0;
    else if (wrap_c) cnt_d = '0;
    else if (step_c) cnt_d = cnt_q + CNT_W'(1);
  end

  // Double buffer: a load landing on a boundary (or while idle) goes straight to active.
  always_comb begin
    active_d  = active_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (!en || wrap_c) begin
      if (duty_load) begin
        active_d = duty_clamped_c;
        pend_d   = duty_clamped_c;
      end else if (pending_q) begin
        active_d = pend_q;
      end
      pending_d = 1'b0;
    end else if (duty_load) begin
      pend_d    = duty_clamped_c;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      active_q  <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      raw_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      tick_q    <= tick_in;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      raw_q     <= DUTY_W'(cnt_q) < active_q;
      ps_q      <= wrap_c;
    end
  end

  pwm_deadtime #(
    .DEAD_CYC (DEAD_CYC),
    .DEAD_W   (DEAD_W)
  ) u_dt (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .raw    (raw_q),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo)
  );

  assign period_start = ps_q;
  assign duty_pending = pending_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen with a short period and a fast tick to bound run time.
module tb_pwm_deadtime_gen;
  import pwm_pkg::*;

  logic       clk;
  logic       rst;
  logic       tick_in;
  logic       en;
  logic [8:0] duty_in;
  logic       duty_load;
  logic       pwm_hi;
  logic       pwm_lo;
  logic       period_start;
  logic       duty_pending;

  int checks = 0;
  int errors = 0;
  int half   = 20;

  // Monitor state
  int cyc_n = 0, hi_cyc = 0, lo_cyc = 0, ps_n = 0, ps_last = 0, ps_int = 0;
  int hi_run = 0, hi_len = 0, hi_falls = 0, overlap_n = 0;
  int gap = 0, side = 0, last_side = 0, last_gap = 0, min_gap = 1000;
  logic hi_prev = 1'b0;

  int h, l, p, k;

  pwm_deadtime_gen #(
    .CNT_W    (8),
    .PERIOD   (10),
    .DEAD_CYC (16),
    .DEAD_W   (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_in      (tick_in),
    .en           (en),
    .duty_in      (duty_in),
    .duty_load    (duty_load),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .period_start (period_start),
    .duty_pending (duty_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the divider output; half period in clk cycles is adjustable.
  initial begin
    tick_in = 1'b0;
    forever begin
      repeat (half) @(negedge clk);
      tick_in = ~tick_in;
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    if (pwm_hi) hi_cyc++;
    if (pwm_lo) lo_cyc++;
    if (pwm_hi && pwm_lo) overlap_n++;
    assert (!(pwm_hi && pwm_lo)) else $error("FAIL overlap hi=%0b lo=%0b", pwm_hi, pwm_lo);
    if (period_start) begin
      ps_int  = cyc_n - ps_last;
      ps_last = cyc_n;
      ps_n++;
    end
    if (pwm_hi) hi_run++;
    else if (hi_prev) begin
      hi_len = hi_run;
      hi_run = 0;
      hi_falls++;
    end
    hi_prev = pwm_hi;
    if (rst || !en) begin
      last_side = 0;
      gap       = 0;
    end else if (pwm_hi || pwm_lo) begin
      side = pwm_hi ? 1 : 2;
      if (last_side != 0 && last_side != side) begin
        last_gap = gap;
        if (gap < min_gap) min_gap = gap;
      end
      gap       = 0;
      last_side = side;
    end else begin
      gap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tcyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load_duty(input int d);
    duty_in   = 9'(d);
    duty_load = 1'b1;
    tcyc(1);
    duty_load = 1'b0;
  endtask

  task automatic wait_ps(input int n, input string tag);
    int target = ps_n + n;
    int cnt    = 0;
    while (ps_n < target && cnt < 3000) begin
      tcyc(1);
      cnt++;
    end
    if (ps_n < target) chk({tag, "_timeout"}, 32'(ps_n), 32'(target));
  endtask

  task automatic wait_hi_fall(input string tag);
    int target = hi_falls + 1;
    int cnt    = 0;
    while (hi_falls < target && cnt < 3000) begin
      tcyc(1);
      cnt++;
    end
    if (hi_falls < target) chk({tag, "_timeout"}, 32'(hi_falls), 32'(target));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; duty_in = '0; duty_load = 1'b0;
    tcyc(5);
    chk("rst_hi", 32'(pwm_hi), 0);
    chk("rst_lo", 32'(pwm_lo), 0);
    chk("rst_ps", 32'(period_start), 0);
    chk("rst_pend", 32'(duty_pending), 0);
    chk("rst_cnt", 32'(dut.cnt_q), 0);

    // Idle with the tick running
    rst = 1'b0;
    h = hi_cyc; l = lo_cyc; p = ps_n;
    tcyc(200);
    chk("idle_hi", 32'(hi_cyc - h), 0);
    chk("idle_lo", 32'(lo_cyc - l), 0);
    chk("idle_ps", 32'(ps_n - p), 0);
    chk("idle_cnt", 32'(dut.cnt_q), 0);

    load_duty(5);
    chk("idle_load_pend", 32'(duty_pending), 0);
    chk("idle_load_active", 32'(dut.active_q), 5);

    // Duty 5/10, 40 clk per step: period 400, hi 5*40-16
    en = 1'b1;
    wait_ps(3, "d5_ps");
    chk("d5_period", 32'(ps_int), 400);
    wait_hi_fall("d5_hi");
    chk("d5_hi_len", 32'(hi_len), 184);
    chk("d5_gap", 32'(last_gap), 16);

    // Mid-period update waits for the boundary
    k = 0;
    while (dut.cnt_q != 8'd3 && k < 1000) begin tcyc(1); k++; end
    load_duty(2);
    chk("mid_pend", 32'(duty_pending), 1);
    chk("mid_active_hold", 32'(dut.active_q), 5);
    wait_ps(1, "mid_ps");
    chk("mid_pend_clr", 32'(duty_pending), 0);
    chk("mid_active", 32'(dut.active_q), 2);
    wait_hi_fall("mid_hi");
    chk("mid_hi_len", 32'(hi_len), 64);

    // Load in the wrap cycle applies at that wrap
    k = 0;
    while (!(dut.cnt_q == 8'd9 && tick_in && !dut.tick_q) && k < 1000) begin tcyc(1); k++; end
    chk("wrap_found", 32'(dut.cnt_q), 9);
    load_duty(7);
    chk("wrap_ps", 32'(period_start), 1);
    chk("wrap_pend", 32'(duty_pending), 0);
    chk("wrap_active", 32'(dut.active_q), 7);
    wait_hi_fall("wrap_hi");
    chk("wrap_hi_len", 32'(hi_len), 264);

    // Duty extremes
    load_duty(0);
    wait_ps(2, "d0_ps");
    h = hi_cyc; l = lo_cyc;
    tcyc(400);
    chk("d0_lo", 32'(lo_cyc - l), 400);
    chk("d0_hi", 32'(hi_cyc - h), 0);

    load_duty(10);
    wait_ps(2, "dmax_ps");
    h = hi_cyc; l = lo_cyc;
    tcyc(400);
    chk("dmax_hi", 32'(hi_cyc - h), 400);
    chk("dmax_lo", 32'(lo_cyc - l), 0);

    load_duty(0);
    wait_ps(2, "clamp_pre_ps");
    load_duty(300);
    chk("clamp_pend", 32'(duty_pending), 1);
    wait_ps(2, "clamp_ps");
    chk("clamp_active", 32'(dut.active_q), 10);
    h = hi_cyc;
    tcyc(400);
    chk("clamp_hi", 32'(hi_cyc - h), 400);

    // Raw pulse of 8 clk, shorter than the dead time
    half = 4;
    load_duty(1);
    wait_ps(2, "abort_ps");
    h = hi_cyc; l = lo_cyc;
    tcyc(240);
    chk("abort_hi", 32'(hi_cyc - h), 0);
    chk("abort_lo", 32'(lo_cyc - l), 216);

    // Disable while HIGH
    half = 20;
    load_duty(5);
    wait_ps(2, "dis_ps");
    k = 0;
    while (!pwm_hi && k < 1000) begin tcyc(1); k++; end
    chk("dis_found_hi", 32'(pwm_hi), 1);
    en = 1'b0;
    tcyc(1);
    chk("dis_hi", 32'(pwm_hi), 0);
    chk("dis_lo", 32'(pwm_lo), 0);
    chk("dis_cnt", 32'(dut.cnt_q), 0);
    p = ps_n;
    tcyc(50);
    chk("dis_no_ps", 32'(ps_n - p), 0);

    // Reset while in DT_R with a pending duty
    en = 1'b1;
    tcyc(3);
    load_duty(3);
    chk("rdt_pend_set", 32'(duty_pending), 1);
    k = 0;
    while (dut.u_dt.state_q != DT_R && k < 1000) begin tcyc(1); k++; end
    chk("rdt_found", 32'(dut.u_dt.state_q), 32'(DT_R));
    rst = 1'b1;
    tcyc(1);
    chk("rdt_hi", 32'(pwm_hi), 0);
    chk("rdt_lo", 32'(pwm_lo), 0);
    chk("rdt_ps", 32'(period_start), 0);
    chk("rdt_pend", 32'(duty_pending), 0);
    chk("rdt_cnt", 32'(dut.cnt_q), 0);
    chk("rdt_active", 32'(dut.active_q), 0);
    chk("rdt_pend_val", 32'(dut.pend_q), 0);
    chk("rdt_state", 32'(dut.u_dt.state_q), 32'(OFF));
    rst = 1'b0;
    en  = 1'b0;
    tcyc(5);

    chk("no_overlap", 32'(overlap_n), 0);
    chk("min_gap", 32'(min_gap), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Complementary PWM generator directly downstream of the 125 kHz divider. It consumes the divider's square wave `output_125k` as a step strobe and counts one PWM period in steps. It compares the count against a double-buffered duty value and drives a high-side/low-side pair with programmable dead time in `clk` cycles. Duty updates are accepted at any time but take effect only at a period boundary, so no glitch pulses occur.

## Interface
- `CNT_W`, 8: step-counter width; duty width is `CNT_W+1`.
- `PERIOD`, 250: steps per PWM period, 2..2^CNT_W.
- `DEAD_CYC`, 16: dead time in `clk` cycles, at least 1.
- `DEAD_W`, 5: dead-time counter width; must hold `DEAD_CYC-1`.

- `clk`  in  1  system clock; same clock that drives the divider.
- `rst`  in  1  synchronous, active-high reset.
- `tick_in`  in  1  `output_125k` from the divider; sampled in the `clk` domain.
- `en`  in  1  run enable.
- `duty_in`  in  CNT_W+1  requested duty in steps; values above `PERIOD` are clamped to `PERIOD`.
- `duty_load`  in  1  one-cycle strobe; captures `duty_in`.
- `pwm_hi`  out  1  high-side drive.
- `pwm_lo`  out  1  low-side drive.
- `period_start`  out  1  one-cycle pulse when the count wraps to 0.
- `duty_pending`  out  1  a loaded duty is waiting for the next period boundary.

## Operation
- Reset: `cnt`=0, active duty=0, pending duty=0, `duty_pending`=0, `tick_q`=0, FSM=OFF. After reset `pwm_hi`=0, `pwm_lo`=0 and `period_start`=0.
- Step detection: `tick_q` registers `tick_in` every cycle.
  - `step` = `tick_in & ~tick_q`, one step per rising edge. With the divider this is 1 step per 666 `clk` cycles.
- Counter, when `en`=1 and `step`=1:
  - if `cnt`==`PERIOD-1`: `cnt`<=0, `wrap`=1;
  - otherwise `cnt`<=`cnt`+1.
  - No change without `step`.
- Duty load: `duty_load`=1 writes the clamped `duty_in` into pending and sets `duty_pending`. A later load before the boundary overwrites the earlier one; last value wins.
- At `wrap`: if `duty_pending`=1, active <= pending and `duty_pending` is cleared.
  - If `duty_load` and `wrap` occur in the same cycle, the incoming value bypasses pending and becomes active at that wrap. `duty_pending` ends at 0.
- Raw PWM: `raw` is registered as `cnt < active`, compared at full `CNT_W+1` width.
  - Duty 0 gives `raw` constantly 0. Duty `PERIOD` gives `raw` constantly 1.
- `en`=0 (synchronous, takes priority over `step`): `cnt`<=0, FSM<=OFF, both outputs 0 next cycle.
  - Pending duty is applied to active immediately. `period_start` is not pulsed.
- Dead-time FSM, with outputs registered from the state:
  - OFF (hi=0, lo=0): if `en`=1, go to DT_F and load the dead-time counter with `DEAD_CYC-1`.
  - LOW (lo=1): if `raw`=1, go to DT_R and load `DEAD_CYC-1`.
  - DT_R (both 0): if `raw`=0, go to LOW. Else if the dead-time counter is 0, go to HIGH. Else decrement.
  - HIGH (hi=1): if `raw`=0, go to DT_F and load `DEAD_CYC-1`.
  - DT_F (both 0): if `raw`=1, go to DT_R and load `DEAD_CYC-1`. Else if the counter is 0, go to LOW. Else decrement.
- Invariant: `pwm_hi & pwm_lo` is never 1. Every hi/lo transition passes through at least `DEAD_CYC` cycles with both outputs low.
- A mid-operation reset behaves identically to power-on reset on the next edge.

## Timing
- `step` is asserted in the cycle where `tick_in`=1 and `tick_q`=0; `cnt` updates at the end of that cycle.
- `raw` follows `cnt` by 1 cycle. The FSM leaves LOW/HIGH 1 cycle after `raw` changes, so each output edge lags the count edge by 2 cycles.
- High-side on-time = `active`×666 − `DEAD_CYC` clk cycles, for 0 < duty < `PERIOD`.
- `period_start` is registered: it is high for exactly 1 cycle, the first cycle in which `cnt`==0 after a wrap.
- A duty load becomes visible on `raw` in the cycle after the wrap that activates it.

## Structure
- Package `pwm_pkg`:
  - FSM state enum {OFF, LOW, DT_R, HIGH, DT_F};
  - default constants `PWM_PERIOD`=250 and `PWM_DEAD_CYC`=16;
  - a duty clamp function.
- Sub-module `pwm_deadtime`: takes `clk`, `rst`, `en`, `raw`; produces `pwm_hi` and `pwm_lo`. It contains the FSM and dead-time counter.
- Top level holds the step detector, counter and duty double-buffer.

## Test plan
- Reset and idle: apply reset with `en`=0 and the toggling `tick_in` from the divider. Expect `pwm_hi`=`pwm_lo`=0, `cnt` held at 0 and no `period_start`.
- Duty 125 of 250, `en`=1: expect `period_start` every 166,500 clk cycles. Expect `pwm_hi` high for 125×666−16 = 83,234 cycles per period. Expect both outputs low for exactly 16 cycles at each transition.
- Duty extremes: load 0 and expect `pwm_lo` constantly 1 after the boundary. Load 250 and expect `pwm_hi` constantly 1. Load 300 and expect it clamped, behaving as 250.
- Mid-period update: load 50 at `cnt`=10 and expect `duty_pending`=1 and an unchanged waveform until the wrap. Then expect `duty_pending`=0 and the new on-time from the next period. Also check load coincident with wrap: the new value applies in that same period.
- Dead-time abort: drive `DEAD_CYC`=16 with a duty of 1 step while forcing a `raw` high pulse shorter than the dead time. Expect `pwm_hi` never asserted and `pwm_hi & pwm_lo` never 1; keep an assertion for this across all tests.
- Disable and reset mid-run: drop `en` while in HIGH and expect both outputs 0 on the next cycle with `cnt`=0. Assert `rst` during DT_R and expect all reset values on the next edge.
